// File: rtl/alu_share_pkg.sv
// rtl/alu_share_pkg.sv - shared types for the time-shared ALU controller
// Contents: function-code enum, FSM state enum, requester count.
package alu_share_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    ADD  = 2'd0,
    ORR  = 2'd1,
    ANDR = 2'd2,
    CAT  = 2'd3
  } func_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// rtl/alu_share_ctrl_if.sv - request/result handshake bundle for alu_share_ctrl
// Signals: req0_*/req1_* (valid, ready, a, b, func), result_* (valid, ready,
// data, id), busy; op_count0/op_count1 only when ALU_SHARE_OPCOUNT_EN is defined.
// Modports: master = requesters plus result consumer, slave = controller.
interface alu_share_ctrl_if #(
  parameter int N = 4
);
  logic         req0_valid;
  logic         req0_ready;
  logic [N-1:0] req0_a;
  logic [N-1:0] req0_b;
  logic [1:0]   req0_func;

  logic         req1_valid;
  logic         req1_ready;
  logic [N-1:0] req1_a;
  logic [N-1:0] req1_b;
  logic [1:0]   req1_func;

  logic           result_valid;
  logic           result_ready;
  logic [2*N-1:0] result_data;
  logic           result_id;
  logic           busy;

`ifdef ALU_SHARE_OPCOUNT_EN
  logic [7:0] op_count0;
  logic [7:0] op_count1;

  modport master (
    output req0_valid, req0_a, req0_b, req0_func,
    output req1_valid, req1_a, req1_b, req1_func,
    output result_ready,
    input  req0_ready, req1_ready,
    input  result_valid, result_data, result_id, busy,
    input  op_count0, op_count1
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_func,
    input  req1_valid, req1_a, req1_b, req1_func,
    input  result_ready,
    output req0_ready, req1_ready,
    output result_valid, result_data, result_id, busy,
    output op_count0, op_count1
  );
`else
  modport master (
    output req0_valid, req0_a, req0_b, req0_func,
    output req1_valid, req1_a, req1_b, req1_func,
    output result_ready,
    input  req0_ready, req1_ready,
    input  result_valid, result_data, result_id, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_func,
    input  req1_valid, req1_a, req1_b, req1_func,
    input  result_ready,
    output req0_ready, req1_ready,
    output result_valid, result_data, result_id, busy
  );
`endif

endinterface

// File: rtl/alu_rr_arb.sv
// rtl/alu_rr_arb.sv - two-way round-robin grant logic (combinational)
// Ports: req (request bits), ptr (requester holding priority),
//        grant (one-hot, zero when nothing requests), next_ptr (pointer after a grant).
module alu_rr_arb
  import alu_share_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               next_ptr
);

  // After any grant the pointer moves to the requester that did not win,
  // so a lone requester also hands priority to the other side.
  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    case (req)
      2'b01: begin
        grant    = 2'b01;
        next_ptr = 1'b1;
      end
      2'b10: begin
        grant    = 2'b10;
        next_ptr = 1'b0;
      end
      2'b11: begin
        grant    = ptr ? 2'b10 : 2'b01;
        next_ptr = ~ptr;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - two-requester controller time-sharing one N-bit ALU
// Ports: clk, rst (async, active-high), bus (alu_share_ctrl_if.slave).
// Optional: ALU_SHARE_OPCOUNT_EN adds per-requester 8-bit delivered-result counters.
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int N       = 4,
  parameter bit RR_INIT = 1'b0
) (
  input logic          clk,
  input logic          rst,
  alu_share_ctrl_if.slave bus
);

  state_e         state;
  logic           ptr;
  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;
  func_e          func_q;
  logic           id_q;
  logic           result_valid;
  logic [2*N-1:0] result_data;
  logic           result_id;
  logic           busy;

  logic [NUM_REQ-1:0] grant;
  logic               next_ptr;
  logic [2*N-1:0]     alu_out;

  alu_rr_arb u_arb (
    .req      ({bus.req1_valid, bus.req0_valid}),
    .ptr      (ptr),
    .grant    (grant),
    .next_ptr (next_ptr)
  );

  // Ready is the only combinational output; gating with rst keeps it low
  // while reset is held even though the state is already IDLE.
  assign bus.req0_ready = (state == IDLE) && grant[0] && !rst;
  assign bus.req1_ready = (state == IDLE) && grant[1] && !rst;

  assign bus.result_valid = result_valid;
  assign bus.result_data  = result_data;
  assign bus.result_id    = result_id;
  assign bus.busy         = busy;

  always_comb begin
    alu_out = '0;
    case (func_q)
      ADD:  alu_out = {{N{1'b0}}, a_q} + {{N{1'b0}}, b_q};
      ORR:  alu_out[0] = (|a_q) | (|b_q);
      ANDR: alu_out[0] = (&a_q) & (&b_q);
      CAT:  alu_out = {a_q, b_q};
      default: alu_out = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= RR_INIT;
      a_q          <= '0;
      b_q          <= '0;
      func_q       <= ADD;
      id_q         <= 1'b0;
      result_valid <= 1'b0;
      result_data  <= '0;
      result_id    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            a_q    <= grant[1] ? bus.req1_a : bus.req0_a;
            b_q    <= grant[1] ? bus.req1_b : bus.req0_b;
            func_q <= func_e'(grant[1] ? bus.req1_func : bus.req0_func);
            id_q   <= grant[1];
            ptr    <= next_ptr;
            busy   <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          result_data  <= alu_out;
          result_id    <= id_q;
          result_valid <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          // result_data is deliberately left holding the last result.
          if (bus.result_ready) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SHARE_OPCOUNT_EN
  logic [7:0] count0;
  logic [7:0] count1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count0 <= '0;
      count1 <= '0;
    end else if (result_valid && bus.result_ready) begin
      if (result_id) count1 <= count1 + 8'd1;
      else           count0 <= count0 + 8'd1;
    end
  end

  assign bus.op_count0 = count0;
  assign bus.op_count1 = count1;
`endif

endmodule
